// File: rtl/rx_fastshift_ctrl.sv
// rx_fastshift_ctrl
// Fast-shift sequencer for the receive shift register.  When the MAC FSM
// reports the end of a short data field, this block strobes the shift
// register enough times to left-align the received bytes and zero-fill the
// unused byte positions.  It then pulses done for one cycle.
//
// The strobe runs at half the clock rate (high, low, high, low...).  setzero
// stays low from the first strobe through the done cycle.  This matters
// because the shift register performs its final delayed shift one cycle
// after the last strobe, and that shift must also load a zero.

module rx_fastshift_ctrl #(
    parameter int SHIFTS_PER_BYTE = 8,
    parameter int MAX_BYTES       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_i,
    input  logic [3:0] dlc_i,
    input  logic       rtr_i,
    input  logic       abort_i,
    output logic       directshift_o,
    output logic       setzero_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_HI,
        SHIFT_LO,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] count_q, count_d;
    logic       directshift_q, directshift_d;
    logic       setzero_q, setzero_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] dlcClip;
    int         effBytes;
    int         shiftTotal;
    logic [6:0] shiftLoad;

    // Number of missing-byte shifts for the frame being accepted.
    // Remote frames carry no data.  DLC codes above 8 still mean 8 bytes.
    always_comb begin
        dlcClip = (dlc_i > 4'd8) ? 4'd8 : dlc_i;
        if (rtr_i) begin
            effBytes = 0;
        end else if (int'(dlcClip) > MAX_BYTES) begin
            effBytes = MAX_BYTES;
        end else begin
            effBytes = int'(dlcClip);
        end
        shiftTotal = (MAX_BYTES - effBytes) * SHIFTS_PER_BYTE;
        shiftLoad  = 7'(shiftTotal);
    end

    // Next-state logic.
    // abort cancels the sequence from any state and has priority over start.
    // The counter only decrements while it is nonzero, so it cannot wrap.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (abort_i) begin
            state_d = IDLE;
            count_d = 7'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        count_d = shiftLoad;
                        state_d = (shiftLoad == 7'd0) ? DONE : SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (count_q != 7'd0) begin
                        count_d = count_q - 7'd1;
                    end
                    state_d = SHIFT_LO;
                end
                SHIFT_LO: begin
                    state_d = (count_q == 7'd0) ? DONE : SHIFT_HI;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode from the upcoming state.
    // Registering these values makes each output a pure function of the
    // current state.
    always_comb begin
        directshift_d = (state_d == SHIFT_HI);
        setzero_d     = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
    end

    // State, counter and output registers.
    // The reset is synchronous and active-low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            count_q       <= 7'd0;
            directshift_q <= 1'b0;
            setzero_q     <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            directshift_q <= directshift_d;
            setzero_q     <= setzero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign directshift_o = directshift_q;
    assign setzero_o     = setzero_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_rx_fastshift_ctrl.sv
// tb_rx_fastshift_ctrl
// Directed bench for the fast-shift sequencer.
// Each output cycle is compared with a hand-derived expectation.  The
// outputs are packed as {directshift, setzero, busy, done}:
//   idle = 0100, strobe high = 1010, strobe low = 0010, done = 0011.

module tb_rx_fastshift_ctrl;

    localparam logic [3:0] OUT_IDLE = 4'b0100;
    localparam logic [3:0] OUT_HI   = 4'b1010;
    localparam logic [3:0] OUT_LO   = 4'b0010;
    localparam logic [3:0] OUT_DONE = 4'b0011;

    localparam int INJ_NONE  = 0;
    localparam int INJ_START = 1;
    localparam int INJ_ABORT = 2;
    localparam int INJ_RESET = 3;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] dlc;
    logic       rtr;
    logic       abort;
    logic       directshift;
    logic       setzero;
    logic       busy;
    logic       done;

    int vectorCount;
    int missCount;

    rx_fastshift_ctrl #(
        .SHIFTS_PER_BYTE(8),
        .MAX_BYTES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start_i(start),
        .dlc_i(dlc),
        .rtr_i(rtr),
        .abort_i(abort),
        .directshift_o(directshift),
        .setzero_o(setzero),
        .busy_o(busy),
        .done_o(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and land on the following falling edge.
    task automatic stepCycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [3:0] expectedOut(input int k, input int n);
        if (k == 2 * n + 1) return OUT_DONE;
        if (k % 2 == 1)     return OUT_HI;
        return OUT_LO;
    endfunction

    // Start a sequence, optionally inject an event in cycle injAt, and check
    // every cycle up to and including the return to idle.
    task automatic applyStimulus(input string name, input logic [3:0] dlcVal,
                                 input logic rtrVal, input int n,
                                 input int injKind, input int injAt);
        int pulses;
        pulses = 0;
        start  = 1'b1;
        dlc    = dlcVal;
        rtr    = rtrVal;
        stepCycle();
        start = 1'b0;
        dlc   = 4'd0;
        rtr   = ~rtrVal;
        for (int k = 1; k <= 2 * n + 1; k++) begin
            checkOutput($sformatf("%s c%0d", name, k),
                        {28'd0, directshift, setzero, busy, done},
                        {28'd0, expectedOut(k, n)});
            if (directshift) pulses++;
            if (injKind == INJ_START && k == injAt) begin
                start = 1'b1;
                dlc   = 4'd0;
                rtr   = 1'b0;
            end else if (injKind == INJ_START && k == injAt + 1) begin
                start = 1'b0;
            end
            if (injKind == INJ_ABORT && k == injAt) begin
                abort = 1'b1;
                stepCycle();
                checkOutput($sformatf("%s abort idle", name),
                            {28'd0, directshift, setzero, busy, done}, {28'd0, OUT_IDLE});
                abort = 1'b0;
                return;
            end
            if (injKind == INJ_RESET && k == injAt) begin
                reset = 1'b0;
                stepCycle();
                checkOutput($sformatf("%s reset idle", name),
                            {28'd0, directshift, setzero, busy, done}, {28'd0, OUT_IDLE});
                start = 1'b1;
                abort = 1'b1;
                stepCycle();
                checkOutput($sformatf("%s reset prio", name),
                            {28'd0, directshift, setzero, busy, done}, {28'd0, OUT_IDLE});
                start = 1'b0;
                abort = 1'b0;
                return;
            end
            stepCycle();
        end
        checkOutput($sformatf("%s idle after", name),
                    {28'd0, directshift, setzero, busy, done}, {28'd0, OUT_IDLE});
        checkOutput($sformatf("%s pulse count", name), 32'(pulses), 32'(n));
        rtr = 1'b0;
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        reset = 1'b0;
        start = 1'b1;
        dlc   = 4'd6;
        rtr   = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        stepCycle();
        checkOutput("reset state", {28'd0, directshift, setzero, busy, done}, {28'd0, OUT_IDLE});
        stepCycle();
        checkOutput("reset holds start", {28'd0, directshift, setzero, busy, done},
                    {28'd0, OUT_IDLE});
        start = 1'b0;
        reset = 1'b1;
        stepCycle();
        checkOutput("idle after release", {28'd0, directshift, setzero, busy, done},
                    {28'd0, OUT_IDLE});

        applyStimulus("dlc6", 4'd6, 1'b0, 16, INJ_NONE, 0);
        applyStimulus("dlc8", 4'd8, 1'b0, 0, INJ_NONE, 0);
        applyStimulus("dlc13", 4'd13, 1'b0, 0, INJ_NONE, 0);
        applyStimulus("dlc0", 4'd0, 1'b0, 64, INJ_NONE, 0);
        applyStimulus("rtr dlc3", 4'd3, 1'b1, 64, INJ_NONE, 0);
        applyStimulus("dlc1", 4'd1, 1'b0, 56, INJ_NONE, 0);
        applyStimulus("dlc7 restart", 4'd7, 1'b0, 8, INJ_START, 3);

        applyStimulus("dlc4 abort", 4'd4, 1'b0, 32, INJ_ABORT, 10);
        applyStimulus("post abort", 4'd7, 1'b0, 8, INJ_NONE, 0);

        start = 1'b1;
        abort = 1'b1;
        dlc   = 4'd2;
        stepCycle();
        checkOutput("abort beats start", {28'd0, directshift, setzero, busy, done},
                    {28'd0, OUT_IDLE});
        start = 1'b0;
        abort = 1'b0;

        applyStimulus("dlc5 reset", 4'd5, 1'b0, 24, INJ_RESET, 7);
        reset = 1'b1;
        applyStimulus("post reset", 4'd8, 1'b0, 0, INJ_NONE, 0);
        applyStimulus("dlc6 again", 4'd6, 1'b0, 16, INJ_NONE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/rx_fastshift_ctrl.md
RX_FASTSHIFT_CTRL -- requirements
Module: rx_fastshift_ctrl

Interface
REQ-001 Parameter: SHIFTS_PER_BYTE, default 8, register shifts per missing data byte.
REQ-002 Parameter: MAX_BYTES, default 8, data-field capacity of the receive shift register in bytes.
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  MAC FSM pulse at end of received data field; request fast-shift.
REQ-006 dlc  input  4  received data length code, sampled only with accepted start.
REQ-007 rtr  input  1  remote frame flag, sampled only with accepted start.
REQ-008 abort  input  1  MAC FSM error/bus-off; cancel any fast-shift.
REQ-009 directshift  output  1  fast-shift strobe to receive shift register (clock/2 pattern).
REQ-010 setzero  output  1  to receive shift register; 1 = pass bitin, 0 = force 0 into register.
REQ-011 busy  output  1  fast-shift sequence in progress.
REQ-012 done  output  1  one-cycle pulse: data field left-aligned, register contents valid.

Function
REQ-013 Outputs SHALL be Moore outputs decoded from registered state; no combinational path from inputs to outputs.
REQ-014 States SHALL be IDLE, SHIFT_HI, SHIFT_LO, DONE.
REQ-015 Byte count SHALL be eff = 0 if rtr=1, else min(dlc, MAX_BYTES); dlc 9..15 SHALL be treated as 8.
REQ-016 Shift count SHALL be N = (MAX_BYTES - eff) * SHIFTS_PER_BYTE, held in a 7-bit down-counter (range 0..64).
REQ-017 IDLE: directshift=0, setzero=1, busy=0, done=0; start=1 and abort=0 -> load counter with N; N=0 -> DONE, else -> SHIFT_HI.
REQ-018 SHIFT_HI: directshift=1, setzero=0, busy=1; next edge -> SHIFT_LO, counter decrements by 1.
REQ-019 SHIFT_LO: directshift=0, setzero=0, busy=1; counter=0 -> DONE, else -> SHIFT_HI.
REQ-020 DONE: directshift=0, setzero=0, busy=1, done=1 for exactly one cycle; next edge -> IDLE.
REQ-021 setzero SHALL stay 0 through DONE so the register's last delayed shift (one cycle after the final directshift high) loads 0.
REQ-022 directshift SHALL never be high in two consecutive cycles; exactly N high cycles per sequence.
REQ-023 Sequence latency: start accepted at edge E0, done high in cycle 2N+1 after E0 (N>0), cycle 1 after E0 (N=0).
REQ-024 start while not in IDLE SHALL be ignored; dlc/rtr changes after acceptance SHALL have no effect.
REQ-025 abort=1 in any state SHALL force IDLE at next edge with no done pulse; abort has priority over start.
REQ-026 Counter SHALL never wrap below 0; no underflow path exists.

Reset
REQ-027 reset=0 at a rising edge SHALL force IDLE, counter=0, directshift=0, setzero=1, busy=0, done=0, regardless of state.
REQ-028 reset SHALL have priority over abort and start; reset mid-sequence SHALL produce no done pulse.
REQ-029 After reset release, first start accepted at the first edge with reset=1.

Verification
REQ-030 dlc=6, rtr=0, start pulse -> 16 directshift pulses alternating 1/0, setzero=0 for 33 cycles, done in cycle 33, then IDLE.
REQ-031 dlc=8 and dlc=13 -> zero directshift pulses, done in cycle 1, busy high one cycle only.
REQ-032 dlc=0 and (rtr=1, dlc=3) -> 64 directshift pulses, done in cycle 129.
REQ-033 dlc=4, abort at cycle 10 -> directshift=0 and setzero=1 from cycle 11, no done; start in cycle 12 re-accepted.
REQ-034 dlc=7, second start at cycle 3 with dlc=0 -> ignored, 8 pulses only, done in cycle 17.
REQ-035 dlc=5, reset=0 at cycle 7 -> outputs return to reset values next cycle, no done.
